// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode, state and width definitions for the ALU operation sequencer.
// Imported by the decoder and by the sequencer top.
package alu_seq_pkg;

   localparam int CTL_W = 13;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd5;
   localparam logic [3:0] OP_SHR   = 4'd6;
   localparam logic [3:0] OP_SHL   = 4'd7;
   localparam logic [3:0] OP_ROR   = 4'd8;
   localparam logic [3:0] OP_ROL   = 4'd9;
   localparam logic [3:0] OP_NEG   = 4'd10;
   localparam logic [3:0] OP_NOT   = 4'd11;
   localparam logic [3:0] OP_INCPC = 4'd12;
   localparam logic [3:0] OP_LAST  = OP_INCPC;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CAPT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU control, EXEC cycle count and
// illegal-opcode flag for a 4-bit opcode.
module alu_op_decode
   import alu_seq_pkg::*;
#(
   parameter int BASE_CYCLES = 1,
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_CYCLES  = 34,
   parameter int CNT_W       = 6
) (
   input  logic [3:0]       op,
   output logic [CTL_W-1:0] ctl,
   output logic [CNT_W-1:0] cycles,
   output logic             illegal
);

   // Opcodes above OP_LAST produce no control bit at all so they can never reach the ALU
   always_comb begin
      ctl     = '0;
      cycles  = CNT_W'(BASE_CYCLES);
      illegal = 1'b0;
      if (op > OP_LAST) begin
         illegal = 1'b1;
      end else begin
         ctl = CTL_W'(1) << op;
      end
      case (op)
         OP_MUL:  cycles = CNT_W'(MUL_CYCLES);
         OP_DIV:  cycles = CNT_W'(DIV_CYCLES);
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: request handshake, timed EXEC window with
// one-hot control, result capture, and a held response; traps bad ops before the ALU.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int BASE_CYCLES = 1,
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_CYCLES  = 34
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [31:0]       req_a,
   input  logic [31:0]       req_b,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [CTL_W-1:0]  alu_ctl,
   input  logic [63:0]       alu_c,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_hi,
   output logic [31:0]       rsp_lo,
   output logic              rsp_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(max3(BASE_CYCLES, MUL_CYCLES, DIV_CYCLES) + 1);

   generate
      if (BASE_CYCLES < 1 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
         $error("alu_op_sequencer: cycle parameters must all be >= 1");
      end
   endgenerate

   state_t             state, next_state;
   logic [3:0]         op_reg;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         dec_op;
   logic [CTL_W-1:0]   dec_ctl;
   logic [CNT_W-1:0]   dec_cycles;
   logic               dec_illegal;
   logic               take_err;

   // The decoder looks at the incoming opcode while idle and the latched one afterwards
   assign dec_op   = (state == S_IDLE) ? req_op : op_reg;
   assign take_err = dec_illegal | ((req_op == OP_DIV) & (req_b == '0));

   alu_op_decode #(
      .BASE_CYCLES (BASE_CYCLES),
      .MUL_CYCLES  (MUL_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_decode (
      .op      (dec_op),
      .ctl     (dec_ctl),
      .cycles  (dec_cycles),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      alu_ctl    = '0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               next_state = take_err ? S_RESP : S_EXEC;
            end
         end
         S_EXEC: begin
            alu_ctl = dec_ctl;
            if (cnt == CNT_W'(1)) begin
               next_state = S_CAPT;
            end
         end
         S_CAPT: begin
            next_state = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Error responses are written at accept time; normal results only on the CAPT edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg  <= OP_AND;
         alu_a   <= '0;
         alu_b   <= '0;
         cnt     <= '0;
         rsp_hi  <= '0;
         rsp_lo  <= '0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_reg <= req_op;
                  alu_a  <= req_a;
                  alu_b  <= req_b;
                  if (take_err) begin
                     cnt     <= '0;
                     rsp_err <= 1'b1;
                     rsp_hi  <= '0;
                     rsp_lo  <= '0;
                  end else begin
                     cnt <= dec_cycles;
                  end
               end
            end
            S_EXEC: begin
               cnt <= cnt - CNT_W'(1);
            end
            S_CAPT: begin
               rsp_hi  <= alu_c[63:32];
               rsp_lo  <= alu_c[31:0];
               rsp_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
